exec_unit: RTL and testbench
============================

# exec_unit

Multi-cycle execute/writeback controller for the cirno core, on the opposite side of the combinational `alu`. It accepts decoded ALU instructions over a valid/ready handshake and owns the 8×8-bit architectural register file. It drives the ALU operands and function code, captures the ALU result and equality output, and writes the result back. It also maintains the architectural `eq` flag used by later branch logic.

## Interface
Parameters:
- `NREGS`, 8: number of architectural registers. Must be a power of two; address width is `$clog2(NREGS)`.
- `W`, 8: datapath width; matches the ALU.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  decoded instruction present.
- `in_ready`  out  1  unit can accept an instruction.
- `in_funct`  in  4  ALU function code, passed through unchanged.
- `in_rd`  in  3  destination register and first operand.
- `in_rs`  in  3  second operand register.
- `in_use_imm`  in  1  second operand is `in_imm` instead of `R[in_rs]`.
- `in_imm`  in  8  immediate value.
- `alu_x`, `alu_y`  out  8  ALU operands.
- `alu_funct`  out  4  ALU function code.
- `alu_result`  in  8  ALU result (combinational from `alu_x`, `alu_y`, `alu_funct`).
- `alu_eq`  in  1  ALU equality output.
- `eq_flag`  out  1  architectural compare flag.
- `wb_valid`  out  1  one-cycle pulse when an instruction retires.
- `wb_rd`  out  3  destination register of the retiring instruction.
- `wb_data`  out  8  result value of the retiring instruction.
- `dbg_addr`  in  3  register-file debug read address.
- `dbg_data`  out  8  `R[dbg_addr]`, combinational read.

## Operation
- FSM states: IDLE, EXEC, WB. Reset state is IDLE.
- IDLE:
  - `in_ready`=1.
  - On `in_valid`&&`in_ready`, latch funct, rd, rs, use_imm and imm into the instruction register, then go to EXEC.
- EXEC:
  - `alu_x`=R[rd].
  - `alu_y`=use_imm ? imm : R[rs].
  - `alu_funct`=latched funct.
  - Capture `alu_result` into the result register and `alu_eq` into the eq register, then go to WB.
- WB:
  - `wb_valid`=1, `wb_rd`=latched rd, `wb_data`=result register.
  - If funct==4'b0110 (cmp): `eq_flag` ← captured eq; the register file is not written.
  - Otherwise: R[rd] ← result; `eq_flag` is unchanged.
  - Next state is IDLE.
- Outside EXEC: `alu_x`, `alu_y` and `alu_funct` are driven to 0.
- Outside WB: `wb_valid`=0, and `wb_rd`/`wb_data` are 0.
- Function codes are not validated. Unknown codes pass through to the ALU, which treats them as the `sh` operation, and they write back like any non-cmp operation.
- Width rules:
  - All arithmetic is performed by the ALU modulo 2^8.
  - The unit performs no extension or saturation.
  - rd==rs is legal; both operands read the same pre-write value.
- Reset:
  - Clears all registers, `eq_flag`, the instruction register, the result register and the FSM.
  - Reset during EXEC or WB abandons the instruction: no write, no `wb_valid`, `eq_flag`=0.
- Debug read: `dbg_data` reflects a write on the cycle after the WB edge. There is no write-to-read bypass.

## Timing
- Reset values: `in_ready`=1, `eq_flag`=0, `wb_valid`=0, `wb_rd`=0, `wb_data`=0, `alu_*`=0, every R[i]=0.
- Handshake accepted at the end of cycle N (IDLE).
- Cycle N+1: EXEC, ALU driven; `in_ready`=0.
- Cycle N+2: WB, `wb_valid`=1; the register or flag updates at the end of N+2; `in_ready`=0.
- Cycle N+3: IDLE, `in_ready`=1; the new value is visible on `dbg_data` and to the next instruction's operand read.
- Peak throughput: one instruction per 3 cycles.
- Back-to-back dependent instructions need no hazard logic, because operands are read in EXEC, after the previous WB.
- Input fields are sampled only at the accepting edge. They may change freely while `in_ready`=0.

## Structure
- Shared package `cirno_pkg` holds:
  - funct constants: `FN_ADD`=0101, `FN_SUB`=0100, `FN_SHL`=1110, `FN_SHR`=0111, `FN_XOR`=0001, `FN_AND`=0011, `FN_OR`=0010, `FN_CMP`=0110, `FN_SH`=1010.
  - the FSM state enum `exec_state_t`.
  - a packed struct `exec_instr_t` containing funct, rd, rs, use_imm and imm.
- One sub-module, `regfile`, contains:
  - `NREGS`×`W` storage;
  - two combinational read ports, for operands;
  - one combinational read port, for debug;
  - one synchronous write port with write enable;
  - synchronous reset.
- The ALU is instantiated beside `exec_unit` at the top level, not inside it.

## Test plan
- Reset, then `dbg_addr` sweep 0–7 → all `dbg_data`=0; `in_ready`=1; `eq_flag`=0.
- Load via immediate: OR R1 with imm 0x3C (R1=0), accepted at cycle N → `wb_valid` at N+2 with `wb_rd`=1, `wb_data`=0x3C; R1=0x3C at N+3.
- Dependent chain: R1=0xF0, R2=0x20; ADD R1,R2 then SUB R1 with imm 0x01, issued back-to-back → R1=0x10, then 0x0F; `in_ready` low for exactly 2 cycles after each accept.
- Compare: R3=0x55; CMP R3 with imm 0x55 → `eq_flag`=1 and R3 unchanged. Then CMP R3 with imm 0x54 → `eq_flag`=0.
- Shifts through the ALU: R4=0x81; SH with imm 0x0A → R4=0x20. Then SHL with imm 0x09 → R4=0x00.
- Reset asserted in the EXEC cycle of ADD R5 with imm 0x07 → no `wb_valid`; R5=0; FSM in IDLE with `in_ready`=1 on the cycle after reset deasserts.

Source files
------------

// File: rtl/cirno_pkg.sv
// Shared definitions for the cirno execute/writeback path: ALU function codes,
// the execute FSM state type and the latched instruction format.
package cirno_pkg;

    localparam logic [3:0] FN_ADD = 4'b0101;
    localparam logic [3:0] FN_SUB = 4'b0100;
    localparam logic [3:0] FN_SHL = 4'b1110;
    localparam logic [3:0] FN_SHR = 4'b0111;
    localparam logic [3:0] FN_XOR = 4'b0001;
    localparam logic [3:0] FN_AND = 4'b0011;
    localparam logic [3:0] FN_OR  = 4'b0010;
    localparam logic [3:0] FN_CMP = 4'b0110;
    localparam logic [3:0] FN_SH  = 4'b1010;

    localparam int FUNCT_W = 4;
    localparam int REG_AW  = 3;
    localparam int DATA_W  = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_WB   = 2'd2
    } exec_state_t;

    typedef struct packed {
        logic [FUNCT_W-1:0] funct;
        logic [REG_AW-1:0]  rd;
        logic [REG_AW-1:0]  rs;
        logic               use_imm;
        logic [DATA_W-1:0]  imm;
    } exec_instr_t;

    function automatic logic is_cmp(input logic [FUNCT_W-1:0] funct);
        return funct == FN_CMP;
    endfunction

endpackage

// File: rtl/exec_unit_regfile.sv
// Architectural register file: two operand read ports, one debug read port,
// one synchronous write port. Reads are combinational with no write bypass.
module regfile #(
    parameter int NREGS = 8,
    parameter int W     = 8,
    parameter int AW    = $clog2(NREGS)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [AW-1:0] raddr_a,
    output logic [W-1:0]  rdata_a,
    input  logic [AW-1:0] raddr_b,
    output logic [W-1:0]  rdata_b,
    input  logic [AW-1:0] dbg_addr,
    output logic [W-1:0]  dbg_data,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata
);

    logic [W-1:0] mem [NREGS];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata_a  = mem[raddr_a];
    assign rdata_b  = mem[raddr_b];
    assign dbg_data = mem[dbg_addr];

endmodule

// File: rtl/exec_unit.sv
// Execute/writeback controller: accepts one decoded instruction, drives the
// external ALU for one cycle, then retires the result into the register file.
//
// state   | meaning
// --------+----------------------------------------------------------
// IDLE    | ready for an instruction; latches it on in_valid
// EXEC    | operands on the ALU; result and eq captured at cycle end
// WB      | wb_valid pulse; register or eq_flag updated at cycle end
module exec_unit
    import cirno_pkg::*;
#(
    parameter int NREGS = 8,
    parameter int W     = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [3:0]               in_funct,
    input  logic [$clog2(NREGS)-1:0] in_rd,
    input  logic [$clog2(NREGS)-1:0] in_rs,
    input  logic                     in_use_imm,
    input  logic [W-1:0]             in_imm,
    output logic [W-1:0]             alu_x,
    output logic [W-1:0]             alu_y,
    output logic [3:0]               alu_funct,
    input  logic [W-1:0]             alu_result,
    input  logic                     alu_eq,
    output logic                     eq_flag,
    output logic                     wb_valid,
    output logic [$clog2(NREGS)-1:0] wb_rd,
    output logic [W-1:0]             wb_data,
    input  logic [$clog2(NREGS)-1:0] dbg_addr,
    output logic [W-1:0]             dbg_data
);

    localparam int AW = $clog2(NREGS);

    exec_state_t state;
    exec_instr_t instr;
    logic [W-1:0] result_q;
    logic         eq_q;

    logic [W-1:0] rdata_x;
    logic [W-1:0] rdata_y;
    logic         rf_we;

    // Writes land at the end of WB, so the next instruction's EXEC read
    // always sees them without any forwarding.
    assign rf_we = (state == ST_WB) && !is_cmp(instr.funct);

    regfile #(
        .NREGS(NREGS),
        .W    (W),
        .AW   (AW)
    ) u_regfile (
        .clk     (clk),
        .reset   (reset),
        .raddr_a (instr.rd),
        .rdata_a (rdata_x),
        .raddr_b (instr.rs),
        .rdata_b (rdata_y),
        .dbg_addr(dbg_addr),
        .dbg_data(dbg_data),
        .we      (rf_we),
        .waddr   (instr.rd),
        .wdata   (result_q)
    );

    always_comb begin
        alu_x     = '0;
        alu_y     = '0;
        alu_funct = '0;
        if (state == ST_EXEC) begin
            alu_x     = rdata_x;
            alu_y     = instr.use_imm ? instr.imm : rdata_y;
            alu_funct = instr.funct;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            instr    <= '0;
            result_q <= '0;
            eq_q     <= 1'b0;
            eq_flag  <= 1'b0;
            in_ready <= 1'b1;
            wb_valid <= 1'b0;
            wb_rd    <= '0;
            wb_data  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        instr.funct   <= in_funct;
                        instr.rd      <= in_rd;
                        instr.rs      <= in_rs;
                        instr.use_imm <= in_use_imm;
                        instr.imm     <= in_imm;
                        in_ready      <= 1'b0;
                        state         <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    result_q <= alu_result;
                    eq_q     <= alu_eq;
                    wb_valid <= 1'b1;
                    wb_rd    <= instr.rd;
                    wb_data  <= alu_result;
                    state    <= ST_WB;
                end
                ST_WB: begin
                    if (is_cmp(instr.funct)) begin
                        eq_flag <= eq_q;
                    end
                    wb_valid <= 1'b0;
                    wb_rd    <= '0;
                    wb_data  <= '0;
                    in_ready <= 1'b1;
                    state    <= ST_IDLE;
                end
                default: begin
                    wb_valid <= 1'b0;
                    wb_rd    <= '0;
                    wb_data  <= '0;
                    in_ready <= 1'b1;
                    state    <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_exec_unit.sv
// Bench for exec_unit: a stand-in ALU plus an instruction-level model of the
// register file and eq flag, exercised with directed and random programs.
module tb_exec_unit;
    import cirno_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_funct;
    logic [2:0] in_rd;
    logic [2:0] in_rs;
    logic       in_use_imm;
    logic [7:0] in_imm;
    logic [7:0] alu_x;
    logic [7:0] alu_y;
    logic [3:0] alu_funct;
    logic [7:0] alu_result;
    logic       alu_eq;
    logic       eq_flag;
    logic       wb_valid;
    logic [2:0] wb_rd;
    logic [7:0] wb_data;
    logic [2:0] dbg_addr;
    logic [7:0] dbg_data;

    logic [7:0] rf_m [8];
    logic       eq_m;
    int         errors = 0;
    int         checks = 0;

    always #5 clk = ~clk;

    exec_unit #(.NREGS(8), .W(8)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_funct(in_funct), .in_rd(in_rd), .in_rs(in_rs),
        .in_use_imm(in_use_imm), .in_imm(in_imm),
        .alu_x(alu_x), .alu_y(alu_y), .alu_funct(alu_funct),
        .alu_result(alu_result), .alu_eq(alu_eq),
        .eq_flag(eq_flag),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    // Stand-in ALU; sh uses y[3] as direction (1 = right) and y[2:0] as amount.
    function automatic logic [7:0] alu_f(input logic [3:0] f, input logic [7:0] x, input logic [7:0] y);
        case (f)
            FN_ADD: return x + y;
            FN_SUB: return x - y;
            FN_SHL: return (y > 8'd7) ? 8'h00 : (x << y[2:0]);
            FN_SHR: return (y > 8'd7) ? 8'h00 : (x >> y[2:0]);
            FN_XOR: return x ^ y;
            FN_AND: return x & y;
            FN_OR:  return x | y;
            FN_CMP: return x - y;
            default: return y[3] ? (x >> y[2:0]) : (x << y[2:0]);
        endcase
    endfunction

    always_comb begin
        alu_result = alu_f(alu_funct, alu_x, alu_y);
        alu_eq     = (alu_x == alu_y);
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    function automatic void clear_model();
        for (int i = 0; i < 8; i++) rf_m[i] = 8'h00;
        eq_m = 1'b0;
    endfunction

    // Called at a negedge+settle point with the unit idle; returns at the N+3 sample point.
    task automatic exec_instr(input logic [3:0] f, input logic [2:0] rd, input logic [2:0] rs,
                              input logic ui, input logic [7:0] imm);
        logic [7:0] x, y, res;
        x   = rf_m[rd];
        y   = ui ? imm : rf_m[rs];
        res = alu_f(f, x, y);
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL accept_ready: in_ready=%b expected 1", in_ready);
        end
        in_valid = 1'b1; in_funct = f; in_rd = rd; in_rs = rs; in_use_imm = ui; in_imm = imm;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_funct = 4'($urandom); in_rd = 3'($urandom); in_rs = 3'($urandom);
        in_use_imm = 1'($urandom); in_imm = 8'($urandom);
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b0 || wb_valid !== 1'b0) begin
            errors++; $display("FAIL exec_ctrl: in_ready=%b wb_valid=%b expected 0 0", in_ready, wb_valid);
        end
        checks++;
        if (alu_x !== x || alu_y !== y || alu_funct !== f) begin
            errors++; $display("FAIL exec_operands: x=%h y=%h f=%h expected %h %h %h", alu_x, alu_y, alu_funct, x, y, f);
        end
        @(negedge clk);
        checks++;
        if (wb_valid !== 1'b1 || wb_rd !== rd || wb_data !== res) begin
            errors++; $display("FAIL writeback: valid=%b rd=%0d data=%h expected 1 %0d %h", wb_valid, wb_rd, wb_data, rd, res);
        end
        checks++;
        if (in_ready !== 1'b0 || alu_x !== 8'h00 || alu_funct !== 4'h0) begin
            errors++; $display("FAIL wb_idle_alu: in_ready=%b alu_x=%h alu_funct=%h expected 0 00 0", in_ready, alu_x, alu_funct);
        end
        if (f == FN_CMP) eq_m = (x == y);
        else rf_m[rd] = res;
        @(negedge clk);
        dbg_addr = rd; #1;
        checks++;
        if (in_ready !== 1'b1 || wb_valid !== 1'b0 || wb_rd !== 3'd0 || wb_data !== 8'h00) begin
            errors++; $display("FAIL post_wb: ready=%b valid=%b rd=%0d data=%h expected 1 0 0 00", in_ready, wb_valid, wb_rd, wb_data);
        end
        checks++;
        if (dbg_data !== rf_m[rd] || eq_flag !== eq_m) begin
            errors++; $display("FAIL retire_state: R%0d=%h eq=%b expected %h %b", rd, dbg_data, eq_flag, rf_m[rd], eq_m);
        end
    endtask

    task automatic check_reg(input logic [2:0] r, input logic [7:0] v, input string name);
        dbg_addr = r; #1;
        checks++;
        if (dbg_data !== v) begin
            errors++; $display("FAIL %s: R%0d=%h expected %h", name, r, dbg_data, v);
        end
    endtask

    task automatic load_reg(input logic [2:0] r, input logic [7:0] v);
        exec_instr(FN_AND, r, 3'd0, 1'b1, 8'h00);
        exec_instr(FN_OR, r, 3'd0, 1'b1, v);
    endtask

    task automatic sweep_zero(input string name);
        for (int i = 0; i < 8; i++) begin
            dbg_addr = 3'(i); #0.5;
            checks++;
            if (dbg_data !== 8'h00) begin
                errors++; $display("FAIL %s: R%0d=%h expected 00", name, i, dbg_data);
            end
        end
        @(negedge clk); #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; in_valid = 1'b0;
        in_funct = '0; in_rd = '0; in_rs = '0; in_use_imm = 1'b0; in_imm = '0; dbg_addr = '0;
        repeat (3) @(posedge clk);
        @(negedge clk); reset = 1'b0; clear_model(); #1;
        checks++;
        if (in_ready !== 1'b1 || eq_flag !== 1'b0 || wb_valid !== 1'b0 || wb_rd !== 3'd0 || wb_data !== 8'h00) begin
            errors++; $display("FAIL reset_ctrl: ready=%b eq=%b valid=%b rd=%0d data=%h", in_ready, eq_flag, wb_valid, wb_rd, wb_data);
        end
        checks++;
        if (alu_x !== 8'h00 || alu_y !== 8'h00 || alu_funct !== 4'h0) begin
            errors++; $display("FAIL reset_alu: x=%h y=%h f=%h expected 0", alu_x, alu_y, alu_funct);
        end
        sweep_zero("reset_regs");
    endtask

    task automatic test_load_imm();
        exec_instr(FN_OR, 3'd1, 3'd0, 1'b1, 8'h3C);
        check_reg(3'd1, 8'h3C, "load_imm");
    endtask

    task automatic test_back_to_back();
        load_reg(3'd1, 8'hF0);
        load_reg(3'd2, 8'h20);
        exec_instr(FN_ADD, 3'd1, 3'd2, 1'b0, 8'hAA);
        check_reg(3'd1, 8'h10, "chain_add");
        exec_instr(FN_SUB, 3'd1, 3'd0, 1'b1, 8'h01);
        check_reg(3'd1, 8'h0F, "chain_sub");
    endtask

    task automatic test_cmp();
        load_reg(3'd3, 8'h55);
        exec_instr(FN_CMP, 3'd3, 3'd0, 1'b1, 8'h55);
        check_reg(3'd3, 8'h55, "cmp_no_write");
        checks++;
        if (eq_flag !== 1'b1) begin
            errors++; $display("FAIL cmp_equal: eq_flag=%b expected 1", eq_flag);
        end
        exec_instr(FN_CMP, 3'd3, 3'd0, 1'b1, 8'h54);
        checks++;
        if (eq_flag !== 1'b0) begin
            errors++; $display("FAIL cmp_unequal: eq_flag=%b expected 0", eq_flag);
        end
    endtask

    task automatic test_shifts();
        load_reg(3'd4, 8'h81);
        exec_instr(FN_SH, 3'd4, 3'd0, 1'b1, 8'h0A);
        check_reg(3'd4, 8'h20, "sh_right");
        exec_instr(FN_SHL, 3'd4, 3'd0, 1'b1, 8'h09);
        check_reg(3'd4, 8'h00, "shl_overflow");
    endtask

    task automatic test_random();
        for (int n = 0; n < 40; n++) begin
            exec_instr(4'($urandom_range(0, 15)), 3'($urandom), 3'($urandom), 1'($urandom), 8'($urandom));
            if ($urandom_range(0, 3) == 0) begin
                @(negedge clk); #1;
            end
        end
    endtask

    task automatic test_reset_mid();
        load_reg(3'd5, 8'h33);
        exec_instr(FN_CMP, 3'd5, 3'd5, 1'b0, 8'h00);
        in_valid = 1'b1; in_funct = FN_ADD; in_rd = 3'd5; in_rs = 3'd0; in_use_imm = 1'b1; in_imm = 8'h07;
        @(posedge clk); #1; in_valid = 1'b0;
        @(negedge clk); reset = 1'b1;
        @(negedge clk); reset = 1'b0; clear_model(); #1;
        checks++;
        if (wb_valid !== 1'b0 || in_ready !== 1'b1 || eq_flag !== 1'b0) begin
            errors++; $display("FAIL reset_mid_ctrl: valid=%b ready=%b eq=%b expected 0 1 0", wb_valid, in_ready, eq_flag);
        end
        check_reg(3'd5, 8'h00, "reset_mid_r5");
        @(negedge clk); #1;
        checks++;
        if (wb_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL reset_mid_late: valid=%b ready=%b expected 0 1", wb_valid, in_ready);
        end
        sweep_zero("reset_mid_regs");
        exec_instr(FN_ADD, 3'd5, 3'd0, 1'b1, 8'h07);
        check_reg(3'd5, 8'h07, "after_reset_add");
    endtask

    initial begin
        test_reset();
        test_load_imm();
        test_back_to_back();
        test_cmp();
        test_shifts();
        test_random();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
